// File: rtl/aes_rx_deser.sv
// aes_rx_deser: strobe-driven deserializer for the AES chip input port.
// Each rising edge of shakehand captures one IN_W-bit beat from rx; OUT_W/IN_W
// beats are packed into one word that is held in a valid/ready output register
// for the key/data loader. Reports dropped words (ovf) and discarded partial
// frames on idle timeout (tmo).
//
// Ports:
//   clk        sole clock, posedge
//   rst        asynchronous active-high reset
//   shakehand  beat strobe, rising edge = one beat
//   rx         beat data, sampled in the rising-edge cycle of shakehand
//   clr        synchronous abort of partial frame and output word
//   data       assembled word, stable while out_valid=1
//   out_valid  data holds an unconsumed word
//   out_ready  consumer accepts data when out_valid & out_ready
//   beat_cnt   beats captured in the current frame
//   ovf        1-cycle pulse: completed word dropped, output occupied
//   tmo        1-cycle pulse: partial frame discarded on timeout
//
// Build option: define AES_RX_DESER_LSB_FIRST_EN to place the first beat in the
// least-significant lane instead of the most-significant lane.
module aes_rx_deser #(
    parameter int unsigned IN_W    = 8,
    parameter int unsigned OUT_W   = 128,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              shakehand,
    input  logic [IN_W-1:0]                   rx,
    input  logic                              clr,
    output logic [OUT_W-1:0]                  data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(OUT_W/IN_W)-1:0]     beat_cnt,
    output logic                              ovf,
    output logic                              tmo
);

    localparam int unsigned NB = OUT_W / IN_W;
    localparam int unsigned CW = $clog2(NB);
    localparam int unsigned OW = $clog2(OUT_W);
    localparam int unsigned IW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   shift, shift_nxt;
    logic [OUT_W-1:0]   data_nxt;
    logic               valid_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic [IW-1:0]      idle_cnt, idle_nxt;
    logic               ovf_nxt, tmo_nxt;
    logic               sh_last;
    logic               armed;

    logic               beat_c;
    logic               last_c;
    logic               tmo_hit_c;
    logic [OW-1:0]      lane_off_c;
    logic [OUT_W-1:0]   word_c;

    // Beat detect; armed blocks a strobe already high at reset release until it falls.
    assign beat_c = shakehand & ~sh_last & armed;
    assign last_c = beat_c && (beat_cnt == CW'(NB - 1));

    // Lane of the current beat within the word.
`ifdef AES_RX_DESER_LSB_FIRST_EN
    assign lane_off_c = OW'(32'(beat_cnt) * IN_W);
`else
    assign lane_off_c = OW'((NB - 1 - 32'(beat_cnt)) * IN_W);
`endif

    // Shift register with this cycle's beat merged in.
    always_comb begin
        word_c = shift;
        word_c[lane_off_c +: IN_W] = rx;
    end

    // A beat in the cycle the idle limit is reached wins over the timeout.
    assign tmo_hit_c = (TMO_CYC != 0) && (state == S_FILL) && !beat_c &&
                       (idle_cnt == IW'(TMO_CYC - 1));

    // Next-state and datapath next values.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        data_nxt  = data;
        valid_nxt = out_valid;
        cnt_nxt   = beat_cnt;
        idle_nxt  = idle_cnt;
        ovf_nxt   = 1'b0;
        tmo_nxt   = 1'b0;

        if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end

        if (clr) begin
            state_nxt = S_IDLE;
            shift_nxt = '0;
            data_nxt  = '0;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
            idle_nxt  = '0;
        end else if (beat_c) begin
            shift_nxt = word_c;
            idle_nxt  = '0;
            if (last_c) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                if (!out_valid || out_ready) begin
                    data_nxt  = word_c;
                    valid_nxt = 1'b1;
                end else begin
                    ovf_nxt = 1'b1;
                end
            end else begin
                state_nxt = S_FILL;
                cnt_nxt   = beat_cnt + CW'(1);
            end
        end else if (tmo_hit_c) begin
            state_nxt = S_IDLE;
            shift_nxt = '0;
            cnt_nxt   = '0;
            idle_nxt  = '0;
            tmo_nxt   = 1'b1;
        end else if (state == S_FILL && TMO_CYC != 0) begin
            idle_nxt = idle_cnt + IW'(1);
        end else begin
            idle_nxt = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shift     <= '0;
            data      <= '0;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            idle_cnt  <= '0;
            ovf       <= 1'b0;
            tmo       <= 1'b0;
            sh_last   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            data      <= data_nxt;
            out_valid <= valid_nxt;
            beat_cnt  <= cnt_nxt;
            idle_cnt  <= idle_nxt;
            ovf       <= ovf_nxt;
            tmo       <= tmo_nxt;
            sh_last   <= shakehand;
            armed     <= armed | ~shakehand;
        end
    end

endmodule
